// File: rtl/mem_a_row_writer_pkg.sv
// Shared memA layout parameters, FSM encoding and range-check helper.
// The memA read path imports the same package so both sides agree on the row layout.
package mem_a_row_writer_pkg;

  localparam int unsigned N            = 20;    // elements per module segment
  localparam int unsigned M            = 4;     // module segments per row
  localparam int unsigned W            = 32;    // bits per element
  localparam int unsigned MEM_A_HEIGHT = 2000;  // highest valid row address
  localparam int unsigned AW           = $clog2(MEM_A_HEIGHT) + 1;

  localparam int unsigned ROW_ELEMS = M * N;
  localparam int unsigned ROW_W     = ROW_ELEMS * W;
  localparam int unsigned IDX_W     = $clog2(ROW_ELEMS);
  localparam int unsigned SEG_W     = $clog2(M);
  localparam int unsigned POS_W     = $clog2(N);
  localparam int unsigned BASE_W    = $clog2(ROW_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Last row touched by a job, one bit wider than an address so it cannot wrap.
  function automatic logic [AW:0] last_row_addr(input logic [AW-1:0] first,
                                                input logic [AW-1:0] count);
    return {1'b0, first} + {1'b0, count} - (AW+1)'(1);
  endfunction

endpackage

// File: rtl/mem_a_row_assembler.sv
// Packs a serial element stream into one memA row; module 1 element 0 lands
// in the top element of the least-significant segment.
module mem_a_row_assembler
  import mem_a_row_writer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic [W-1:0]     in_element,
  output logic [ROW_W-1:0] row_data,
  output logic             row_full_c
);

  logic [IDX_W-1:0]  elem_idx;
  logic [SEG_W-1:0]  seg;
  logic [POS_W-1:0]  pos;
  logic [IDX_W-1:0]  slot;
  logic [BASE_W-1:0] bit_base;

  // Elements fill each segment from its most-significant slot downwards.
  assign slot       = IDX_W'(seg) * IDX_W'(N) + IDX_W'(N - 1) - IDX_W'(pos);
  assign bit_base   = BASE_W'(slot) * BASE_W'(W);
  assign row_full_c = accept && (elem_idx == IDX_W'(ROW_ELEMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_idx <= '0;
      seg      <= '0;
      pos      <= '0;
      row_data <= '0;
    end else if (clear) begin
      elem_idx <= '0;
      seg      <= '0;
      pos      <= '0;
    end else if (accept) begin
      row_data[bit_base +: W] <= in_element;
      if (row_full_c) begin
        elem_idx <= '0;
        seg      <= '0;
        pos      <= '0;
      end else begin
        elem_idx <= elem_idx + IDX_W'(1);
        if (pos == POS_W'(N - 1)) begin
          pos <= '0;
          seg <= seg + SEG_W'(1);
        end else begin
          pos <= pos + POS_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mem_a_row_writer.sv
// Load side of matrix-A memory: streams elements into packed rows and issues
// one row write per address over a range-checked block of rows.
module mem_a_row_writer
  import mem_a_row_writer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_address,
  input  logic [AW-1:0]    row_count,
  input  logic [W-1:0]     in_element,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             memA_write_enable,
  output logic [AW-1:0]    memA_write_address,
  output logic [ROW_W-1:0] memA_write_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  state_e        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] rows_left;
  logic          accept;
  logic          start_take;
  logic          row_full_c;

  assign accept     = in_valid && in_ready;
  assign start_take = start && (state == ST_IDLE);

  mem_a_row_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_take),
    .accept     (accept),
    .in_element (in_element),
    .row_data   (memA_write_data),
    .row_full_c (row_full_c)
  );

  // Job sequencing; in_ready, strobe and done are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      addr               <= '0;
      rows_left          <= '0;
      in_ready           <= 1'b0;
      memA_write_enable  <= 1'b0;
      memA_write_address <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
    end else begin
      memA_write_enable <= 1'b0;
      done              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (row_count == '0) begin
              error <= 1'b0;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else if (last_row_addr(start_address, row_count) > (AW+1)'(MEM_A_HEIGHT)) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              addr      <= start_address;
              rows_left <= row_count;
              error     <= 1'b0;
              busy      <= 1'b1;
              in_ready  <= 1'b1;
              state     <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (row_full_c) begin
            in_ready           <= 1'b0;
            memA_write_enable  <= 1'b1;
            memA_write_address <= addr;
            state              <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          rows_left <= rows_left - AW'(1);
          // Address only advances when another row follows, so it stays in range.
          if (rows_left == AW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            addr     <= addr + AW'(1);
            in_ready <= 1'b1;
            state    <= ST_FILL;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_a_row_writer.sv
// Directed bench for mem_a_row_writer: table of jobs plus reset corner sequences.
module tb_mem_a_row_writer;
  import mem_a_row_writer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    start_address;
  logic [AW-1:0]    row_count;
  logic [W-1:0]     in_element;
  logic             in_valid;
  logic             in_ready;
  logic             memA_write_enable;
  logic [AW-1:0]    memA_write_address;
  logic [ROW_W-1:0] memA_write_data;
  logic             busy;
  logic             done;
  logic             error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_a_row_writer dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .start_address      (start_address),
    .row_count          (row_count),
    .in_element         (in_element),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .memA_write_enable  (memA_write_enable),
    .memA_write_address (memA_write_address),
    .memA_write_data    (memA_write_data),
    .busy               (busy),
    .done               (done),
    .error              (error)
  );

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] rc;
    bit            gaps;
    int            exp_strobes;
    bit            exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_row(input string name, input logic [ROW_W-1:0] act,
                           input logic [ROW_W-1:0] exp);
    bit shown;
    checks++;
    if (act !== exp) begin
      errors++;
      shown = 1'b0;
      for (int i = 0; i < ROW_ELEMS; i++) begin
        if (!shown && act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s word %0d actual=%h required=%h", name, i,
                   act[i*W +: W], exp[i*W +: W]);
          shown = 1'b1;
        end
      end
    end
  endtask

  // Row holding stream values first..first+79, placed by module/element position.
  function automatic logic [ROW_W-1:0] exp_row(input int unsigned first);
    logic [ROW_W-1:0] r;
    int m;
    int e;
    r = '0;
    for (int p = 0; p < ROW_ELEMS; p++) begin
      m = p / N + 1;
      e = p % N;
      r[(m-1)*N*W + (N-e)*W - 1 -: W] = W'(first + p);
    end
    return r;
  endfunction

  task automatic run_job(input logic [AW-1:0] sa, input logic [AW-1:0] rc, input bit gaps,
                         input int exp_strobes, input bit exp_err, input string tag);
    int  strobes = 0;
    int  dones   = 0;
    int  hs      = 0;
    int  k       = 0;
    int  cyc     = 0;
    bit  last_we = 1'b0;
    bit  hs_now;
    @(negedge clk);
    start         = 1'b1;
    start_address = sa;
    row_count     = rc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'(exp_strobes > 0));
    while (dones == 0 && cyc < 2000) begin
      if (memA_write_enable) begin
        check({tag, "_addr"}, 64'(memA_write_address), 64'(sa) + 64'(strobes));
        check({tag, "_handshakes"}, 64'(hs), 64'(ROW_ELEMS));
        check({tag, "_ready_in_write"}, 64'(in_ready), 64'd0);
        check_row({tag, "_data"}, memA_write_data, exp_row(strobes * ROW_ELEMS + 1));
        strobes++;
        hs = 0;
      end
      if (done) begin
        dones++;
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        if (exp_strobes > 0) check({tag, "_done_after_strobe"}, 64'(last_we), 64'd1);
      end
      last_we    = memA_write_enable;
      in_valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_element = W'(k + 1);
      hs_now     = in_valid && in_ready;
      @(posedge clk);
      if (hs_now) begin
        k++;
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_done_seen"}, 64'(dones), 64'd1);
    check({tag, "_strobes"}, 64'(strobes), 64'(exp_strobes));
    check({tag, "_elements"}, 64'(k), 64'(exp_strobes * ROW_ELEMS));
    check({tag, "_single_done"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{sa: AW'(5),    rc: AW'(1), gaps: 1'b0, exp_strobes: 1, exp_err: 1'b0};
    vecs[1] = '{sa: AW'(5),    rc: AW'(1), gaps: 1'b1, exp_strobes: 1, exp_err: 1'b0};
    vecs[2] = '{sa: AW'(1998), rc: AW'(3), gaps: 1'b0, exp_strobes: 3, exp_err: 1'b0};
    vecs[3] = '{sa: AW'(1999), rc: AW'(3), gaps: 1'b0, exp_strobes: 0, exp_err: 1'b1};
    vecs[4] = '{sa: AW'(7),    rc: AW'(0), gaps: 1'b0, exp_strobes: 0, exp_err: 1'b0};
    vecs[5] = '{sa: AW'(2000), rc: AW'(1), gaps: 1'b1, exp_strobes: 1, exp_err: 1'b0};
    vecs[6] = '{sa: AW'(2000), rc: AW'(2), gaps: 1'b0, exp_strobes: 0, exp_err: 1'b1};

    rst = 1'b1; start = 1'b0; start_address = '0; row_count = '0;
    in_element = '0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(in_ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_we", 64'(memA_write_enable), 64'd0);
    check_row("reset_data", memA_write_data, '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].sa, vecs[i].rc, vecs[i].gaps, vecs[i].exp_strobes, vecs[i].exp_err,
              $sformatf("vec%0d", i));
      if (i == 0) begin
        check("spot_m1e0", 64'(memA_write_data[639:608]), 64'h01);
        check("spot_m4e0", 64'(memA_write_data[2559:2528]), 64'h3D);
        check("spot_m4e19", 64'(memA_write_data[1951:1920]), 64'h50);
      end
    end

    // Async reset mid-cycle clears sticky error and the row register immediately.
    run_job(AW'(1999), AW'(3), 1'b0, 0, 1'b1, "err_before_rst");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_error", 64'(error), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_addr", 64'(memA_write_address), 64'd0);
    check_row("async_rst_data", memA_write_data, '0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after 30 elements of a row: no write, then a clean row at address 0.
    @(negedge clk);
    start = 1'b1; start_address = AW'(0); row_count = AW'(1);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 30 && in_ready; n++) begin
      in_valid   = 1'b1;
      in_element = W'(32'hA0 + n);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrow_rst_ready", 64'(in_ready), 64'd0);
    check_row("midrow_rst_data", memA_write_data, '0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("midrow_no_strobe", 64'(memA_write_enable), 64'd0);
    end
    rst = 1'b0;
    run_job(AW'(0), AW'(1), 1'b0, 1, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
